// File: rtl/ext_bus_responder_pkg.sv
// Shared definitions for the external bus command format and responder state.
// Used by the memory controller and by ext_bus_responder.
package ext_bus_responder_pkg;

  localparam int unsigned BUS_W        = 32;
  localparam int unsigned WM_W         = BUS_W / 8;
  localparam int unsigned CMD_WE       = 31;
  localparam int unsigned CMD_ADDR_MSB = 29;
  localparam int unsigned CMD_ADDR_LSB = 0;
  localparam int unsigned CMD_ADDR_W   = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ_TA = 2'd2,
    ST_READ    = 2'd3
  } state_e;

  // Start word address field of a command word; bit 30 is reserved.
  function automatic logic [CMD_ADDR_W-1:0] cmd_addr(input logic [BUS_W-1:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/ext_bus_responder.sv
// Burst responder on the external memory bus, backed by a synchronous SRAM.
// SRAM strobes are combinational so a read issued in cycle N returns data in N+1.
module ext_bus_responder
  import ext_bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_en,
  input  logic [BUS_W-1:0]  IN_bus,
  output logic [BUS_W-1:0]  OUT_bus,
  output logic              OUT_oen,
  output logic              OUT_busy,
  output logic              OUT_MEM_nce,
  output logic              OUT_MEM_nwe,
  output logic [ADDR_W-1:0] OUT_MEM_addr,
  output logic [BUS_W-1:0]  OUT_MEM_data,
  output logic [WM_W-1:0]   OUT_MEM_wm,
  input  logic [BUS_W-1:0]  IN_MEM_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic                cnt_load, cnt_inc;
  logic                oen_d;
  logic                armed_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Word address counter, wraps modulo 2^ADDR_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt_q <= '0;
    else if (cnt_load) cnt_q <= ADDR_W'(cmd_addr(IN_bus));
    else if (cnt_inc)  cnt_q <= cnt_q + ADDR_W'(1);
  end

  // Bus ownership flag; armed requires a low IN_en after reset before a command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_oen <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      OUT_oen <= oen_d;
      if (!IN_en) armed_q <= 1'b1;
    end
  end

  // Next state and SRAM strobes
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    oen_d        = 1'b0;
    OUT_MEM_nce  = 1'b1;
    OUT_MEM_nwe  = 1'b1;
    OUT_MEM_addr = '0;
    OUT_MEM_data = '0;
    OUT_MEM_wm   = '0;
    case (state_q)
      ST_IDLE: begin
        if (IN_en && armed_q) begin
          cnt_load = 1'b1;
          state_d  = IN_bus[CMD_WE] ? ST_WRITE : ST_READ_TA;
        end
      end
      ST_WRITE: begin
        if (IN_en) begin
          OUT_MEM_nce  = 1'b0;
          OUT_MEM_nwe  = 1'b0;
          OUT_MEM_addr = cnt_q;
          OUT_MEM_data = IN_bus;
          OUT_MEM_wm   = '1;
          cnt_inc      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ_TA, ST_READ: begin
        if (IN_en) begin
          OUT_MEM_nce  = 1'b0;
          OUT_MEM_addr = cnt_q;
          cnt_inc      = 1'b1;
          oen_d        = 1'b1;
          state_d      = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign OUT_bus  = OUT_oen ? IN_MEM_data : '0;
  assign OUT_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder: transaction-level expectations per cycle,
// a simple synchronous SRAM behind the DUT, and literal spot checks.
module tb_ext_bus_responder;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_en;
  logic [31:0]       in_bus;
  logic [31:0]       out_bus;
  logic              out_oen, out_busy, mem_nce, mem_nwe;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_wm;
  logic [31:0]       mem_rdata = '0;

  bit [31:0]   sram      [65536];
  bit [31:0]   model_mem [65536];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] rd_q [$];

  logic [31:0] e_bus, e_data;
  logic        e_oen, e_busy, e_nce, e_nwe;
  logic [15:0] e_addr;
  logic [3:0]  e_wm;

  ext_bus_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .IN_en(in_en), .IN_bus(in_bus),
    .OUT_bus(out_bus), .OUT_oen(out_oen), .OUT_busy(out_busy),
    .OUT_MEM_nce(mem_nce), .OUT_MEM_nwe(mem_nwe), .OUT_MEM_addr(mem_addr),
    .OUT_MEM_data(mem_data), .OUT_MEM_wm(mem_wm), .IN_MEM_data(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears one cycle after the access
  always @(posedge clk) begin
    if (mem_nce === 1'b0) begin
      if (mem_nwe === 1'b0) begin
        sram[mem_addr] <= mem_data;
        n_writes++;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus",   out_bus,           e_bus);
      check("oen",   32'(out_oen),      32'(e_oen));
      check("busy",  32'(out_busy),     32'(e_busy));
      check("nce",   32'(mem_nce),      32'(e_nce));
      check("nwe",   32'(mem_nwe),      32'(e_nwe));
      check("addr",  32'(mem_addr),     32'(e_addr));
      check("wdata", mem_data,          e_data);
      check("wm",    32'(mem_wm),       32'(e_wm));
      if (out_oen === 1'b1) rd_q.push_back(out_bus);
    end
  end

  task automatic set_idle();
    e_bus = '0; e_oen = 1'b0; e_busy = 1'b0; e_nce = 1'b1; e_nwe = 1'b1;
    e_addr = '0; e_data = '0; e_wm = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: command cycle, n data cycles, then one IN_en-low cycle
  task automatic burst(input logic [31:0] cmd, input int n, input logic [31:0] base);
    logic [15:0] a, ai;
    bit wr;
    a  = cmd[15:0];
    wr = cmd[31];
    in_en = 1'b1; in_bus = cmd; set_idle();
    tick();
    for (int i = 0; i < n; i++) begin
      ai = a + 16'(i);
      set_idle(); e_busy = 1'b1; e_nce = 1'b0; e_addr = ai;
      if (wr) begin
        in_bus = base + 32'(i);
        e_nwe = 1'b0; e_data = in_bus; e_wm = 4'hF;
        model_mem[ai] = in_bus;
      end else begin
        in_bus = $urandom;
        if (i > 0) begin
          e_oen = 1'b1;
          e_bus = model_mem[ai - 16'd1];
        end
      end
      tick();
    end
    in_en = 1'b0; in_bus = $urandom; set_idle(); e_busy = 1'b1;
    if (!wr && n > 0) begin
      e_oen = 1'b1;
      e_bus = model_mem[a + 16'(n - 1)];
    end
    tick();
  endtask

  logic [31:0] exp_rd [4];

  initial begin
    exp_rd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rst = 1'b0; in_en = 1'b0; in_bus = '0; set_idle(); chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Write burst then read it back
    burst(32'h8000_0010, 4, 32'hA0);
    rd_q.delete();
    burst(32'h0000_0010, 4, '0);
    check("rd_count", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) check("rd_word", rd_q[i], exp_rd[i]);

    // Back-to-back write then read
    burst(32'h8000_0020, 3, 32'hB0);
    burst(32'h0000_0020, 3, '0);

    // Address wrap
    burst(32'h8000_FFFF, 3, 32'hC0);
    check("wrap_ffff", sram[16'hFFFF], 32'hC0);
    check("wrap_0000", sram[16'h0000], 32'hC1);
    check("wrap_0001", sram[16'h0001], 32'hC2);
    burst(32'h0000_FFFE, 4, '0);

    // Reserved bit 30 and upper address bits are ignored
    burst(32'hFFFF_0050, 3, 32'hD0);
    check("hi_bits", sram[16'h0050], 32'hD0);
    burst(32'h7FFF_0050, 3, '0);

    // Zero-length transactions
    rd_q.delete();
    burst(32'h8000_0030, 0, '0);
    burst(32'h0000_0030, 0, '0);
    check("zero_len_oen", 32'(rd_q.size()), 32'd0);

    // Reset in cycle 3 of a read
    in_en = 1'b1; in_bus = 32'h0000_0010; set_idle();
    tick();
    set_idle(); e_busy = 1'b1; e_nce = 1'b0; e_addr = 16'h0010;
    tick();
    e_addr = 16'h0011; e_oen = 1'b1; e_bus = model_mem[16'h0010];
    tick();
    e_addr = 16'h0012; e_bus = model_mem[16'h0011];
    #1 check("pre_rst_oen", 32'(out_oen), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_oen",  32'(out_oen),  32'd0);
    check("rst_nce",  32'(mem_nce),  32'd1);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_bus",  out_bus,       32'd0);
    set_idle();
    tick();
    rst = 1'b1;
    tick();
    tick();
    in_en = 1'b0;
    tick();
    rd_q.delete();
    burst(32'h0000_0010, 4, '0);
    check("post_rst_cnt", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) check("post_rst_word", rd_q[i], exp_rd[i]);

    check("write_count", 32'(n_writes), 32'd13);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
